// File: rtl/count_sampler_pkg.sv
// Shared types and defaults for the ripple-counter sampler.
// Build option: COUNT_SAMPLER_DELTA_EN enables the delta (advance since last capture) path.
package count_sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_SETTLE  = 2;
    localparam int DEF_TIMEOUT = 15;

    // Width of the settle-match and timeout counters.
    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/bus_sync2.sv
// Two-flop synchronizer for a multi-bit bus that changes asynchronously to clk.
module bus_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;

    // Each bit is synchronized on its own; bus coherence is restored downstream.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg[gi] <= 1'b0;
                    s2_reg[gi] <= 1'b0;
                end else begin
                    s1_reg[gi] <= d[gi];
                    s2_reg[gi] <= s1_reg[gi];
                end
            end
        end
    endgenerate

    assign q = s2_reg;

endmodule

// File: rtl/count_sampler.sv
// Samples a free-running ripple counter once it has settled, with a timeout fallback.
// Build option: COUNT_SAMPLER_DELTA_EN builds the last-capture register and subtractor.
module count_sampler
    import count_sampler_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SETTLE  = DEF_SETTLE,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             sample_req,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sample_val,
    output logic [WIDTH-1:0] delta,
    output logic             settle_err
);

    localparam cnt_t SETTLE_C  = cnt_t'(SETTLE);
    localparam cnt_t TIMEOUT_C = cnt_t'(TIMEOUT);

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] prev_reg;
    state_t           state_reg;
    cnt_t             eq_cnt_reg;
    cnt_t             tmo_cnt_reg;
    cnt_t             eq_cnt_next;
    cnt_t             tmo_cnt_next;
    logic [WIDTH-1:0] sample_val_reg;
    logic             settle_err_reg;
    logic             out_valid_reg;
    logic             busy_reg;
`ifdef COUNT_SAMPLER_DELTA_EN
    logic [WIDTH-1:0] last_reg;
    logic [WIDTH-1:0] delta_reg;
`endif

    bus_sync2 #(
        .WIDTH(WIDTH)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (cnt_in),
        .q    (s2)
    );

    always_comb begin
        tmo_cnt_next = tmo_cnt_reg + cnt_t'(1);
        eq_cnt_next  = '0;
        if (s2 == prev_reg) begin
            eq_cnt_next = eq_cnt_reg + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg       <= '0;
            state_reg      <= ST_IDLE;
            eq_cnt_reg     <= '0;
            tmo_cnt_reg    <= '0;
            sample_val_reg <= '0;
            settle_err_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef COUNT_SAMPLER_DELTA_EN
            last_reg       <= '0;
            delta_reg      <= '0;
`endif
        end else begin
            prev_reg <= s2;
            case (state_reg)
                ST_IDLE: begin
                    if (sample_req) begin
                        eq_cnt_reg  <= '0;
                        tmo_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    tmo_cnt_reg <= tmo_cnt_next;
                    eq_cnt_reg  <= eq_cnt_next;
                    // A stable match takes priority over a simultaneous timeout.
                    if (eq_cnt_next == SETTLE_C || tmo_cnt_next == TIMEOUT_C) begin
                        sample_val_reg <= s2;
                        settle_err_reg <= (eq_cnt_next != SETTLE_C);
                        out_valid_reg  <= 1'b1;
                        state_reg      <= ST_HOLD;
`ifdef COUNT_SAMPLER_DELTA_EN
                        delta_reg      <= s2 - last_reg;
                        last_reg       <= s2;
`endif
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign out_valid  = out_valid_reg;
    assign sample_val = sample_val_reg;
    assign settle_err = settle_err_reg;
`ifdef COUNT_SAMPLER_DELTA_EN
    assign delta      = delta_reg;
`else
    assign delta      = '0;
`endif

endmodule

// File: tb/tb_count_sampler.sv
// Randomized self-checking bench for count_sampler against a history-based capture model.
module tb_count_sampler;

    localparam int WIDTH   = 8;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 15;
    localparam int HIST_N  = 8192;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] cnt_in;
    logic             sample_req;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sample_val;
    logic [WIDTH-1:0] delta;
    logic             settle_err;

    always #5 clk = ~clk;

    count_sampler #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_in    (cnt_in),
        .sample_req(sample_req),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sample_val(sample_val),
        .delta     (delta),
        .settle_err(settle_err)
    );

    // Value of cnt_in seen at every rising edge, plus the most recent reset edge.
    logic [WIDTH-1:0] hist [0:HIST_N-1];
    int edge_n   = 0;
    int last_rst = -1;

    always @(posedge clk) begin
        if (edge_n < HIST_N) hist[edge_n] <= cnt_in;
        if (reset) last_rst <= edge_n;
        edge_n <= edge_n + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Input pattern: 0 hold, 1 alternate va/vb every cycle, 2 random every cycle.
    int               mode = 0;
    logic [WIDTH-1:0] va, vb;

    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            1:       cnt_in = (cnt_in == va) ? vb : va;
            2:       cnt_in = WIDTH'($urandom);
            default: ;
        endcase
    endtask

    // Synchronized view of the edge-i sample: the synchronizer holds zero for anything before reset.
    function automatic logic [WIDTH-1:0] syncv(input int i);
        return (i >= 0 && i > last_rst) ? hist[i] : '0;
    endfunction

    // After a request at edge k, the value reaching the checker at edge m was sampled at m-2 and
    // is compared with the one sampled at m-3; SETTLE matches in a row or TIMEOUT edges end it.
    task automatic predict(input int k, output int cap, output logic [WIDTH-1:0] v, output bit err);
        int run = 0;
        cap = k + TIMEOUT;
        v   = syncv(k + TIMEOUT - 2);
        err = 1'b1;
        for (int m = k + 1; m <= k + TIMEOUT; m++) begin
            run = (syncv(m - 2) == syncv(m - 3)) ? run + 1 : 0;
            if (run == SETTLE) begin
                cap = m;
                v   = syncv(m - 2);
                err = 1'b0;
                break;
            end
        end
    endtask

    logic [WIDTH-1:0] last_cap  = '0;
    logic [WIDTH-1:0] exp_val   = '0;
    logic [WIDTH-1:0] exp_delta = '0;
    bit               exp_err   = 1'b0;

    task automatic request(output int k);
        sample_req = 1'b1;
        tick();
        k = edge_n - 1;
        sample_req = 1'b0;
    endtask

    task automatic expect_capture(input int k, input string tag);
        int cap;
        logic [WIDTH-1:0] v;
        bit err;
        bit seen = 1'b0;
        for (int i = 0; i < TIMEOUT + 4 && !seen; i++) begin
            tick();
            seen = out_valid;
        end
        if (!seen) begin
            check_eq({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
            return;
        end
        predict(k, cap, v, err);
        exp_val = v;
        exp_err = err;
`ifdef COUNT_SAMPLER_DELTA_EN
        exp_delta = v - last_cap;
`else
        exp_delta = '0;
`endif
        last_cap = v;
        check_eq({tag, "_latency"}, 32'(edge_n - 1 - k), 32'(cap - k));
        check_eq({tag, "_sample_val"}, 32'(sample_val), 32'(exp_val));
        check_eq({tag, "_delta"}, 32'(delta), 32'(exp_delta));
        check_eq({tag, "_settle_err"}, 32'(settle_err), 32'(exp_err));
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        $display("txn %s: req_edge=%0d cap_edge=%0d val=0x%0h delta=0x%0h err=%0d",
                 tag, k, edge_n - 1, sample_val, delta, settle_err);
    endtask

    // Stall for 'hold' cycles with input churn and stray requests, then complete the handshake.
    task automatic finish_hs(input int hold, input string tag);
        logic req0 = sample_req;
        int   mode0 = mode;
        out_ready = 1'b0;
        if (hold > 0) mode = 2;
        for (int i = 0; i < hold; i++) begin
            sample_req = 1'($urandom_range(0, 1));
            tick();
            check_eq({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_bp_val"}, 32'(sample_val), 32'(exp_val));
            check_eq({tag, "_bp_delta"}, 32'(delta), 32'(exp_delta));
            check_eq({tag, "_bp_err"}, 32'(settle_err), 32'(exp_err));
        end
        mode       = mode0;
        sample_req = req0;
        out_ready  = 1'b1;
        tick();
        check_eq({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_hs_busy"}, 32'(busy), 32'd0);
        if (!req0) begin
            tick();
            check_eq({tag, "_no_queue_busy"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_val"}, 32'(sample_val), 32'd0);
        check_eq({tag, "_delta"}, 32'(delta), 32'd0);
        check_eq({tag, "_err"}, 32'(settle_err), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_cap = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset      = 1'b1;
        sample_req = 1'b0;
        out_ready  = 1'b1;
        cnt_in     = '0;
        va         = '0;
        vb         = '0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        repeat (4) tick();

        // Stable value
        cnt_in = 8'h2A;
        repeat (4) tick();
        request(k);
        expect_capture(k, "stable");
        check_eq("stable_fixed_latency", 32'(edge_n - 1 - k), 32'(SETTLE));
        finish_hs(0, "stable");

        // Wrap-around delta
        cnt_in = 8'hFE;
        repeat (4) tick();
        request(k);
        expect_capture(k, "wrap_a");
        finish_hs(0, "wrap_a");
        cnt_in = 8'h03;
        repeat (4) tick();
        request(k);
        expect_capture(k, "wrap_b");
`ifdef COUNT_SAMPLER_DELTA_EN
        check_eq("wrap_fixed_delta", 32'(delta), 32'h05);
`else
        check_eq("wrap_fixed_delta", 32'(delta), 32'h00);
`endif
        finish_hs(0, "wrap_b");

        // Ripple glitching forces a timeout capture
        va = 8'h7F;
        vb = 8'h80;
        cnt_in = 8'h7F;
        mode = 1;
        repeat (4) tick();
        request(k);
        expect_capture(k, "glitch");
        check_eq("glitch_fixed_err", 32'(settle_err), 32'd1);
        check_eq("glitch_fixed_latency", 32'(edge_n - 1 - k), 32'(TIMEOUT));
        finish_hs(0, "glitch");
        mode = 0;
        cnt_in = 8'h80;
        repeat (4) tick();
        request(k);
        expect_capture(k, "after_glitch");
        finish_hs(0, "after_glitch");

        // Backpressure
        cnt_in = 8'h55;
        repeat (4) tick();
        request(k);
        expect_capture(k, "bp");
        finish_hs(10, "bp");

        // Reset during SETTLE
        cnt_in = 8'h33;
        repeat (4) tick();
        request(k);
        tick();
        pulse_reset();
        check_all_zero("rst_settle");
        cnt_in = 8'h10;
        request(k);
        expect_capture(k, "post_rst_settle");
        finish_hs(0, "post_rst_settle");

        // Reset during HOLD
        cnt_in = 8'h44;
        repeat (4) tick();
        out_ready = 1'b0;
        request(k);
        expect_capture(k, "pre_rst_hold");
        pulse_reset();
        check_all_zero("rst_hold");
        out_ready = 1'b1;
        cnt_in = 8'h10;
        repeat (4) tick();
        request(k);
        expect_capture(k, "post_rst_hold");
        finish_hs(0, "post_rst_hold");

        // Continuous requests: next request is honoured on the first IDLE edge
        cnt_in = 8'h66;
        repeat (4) tick();
        sample_req = 1'b1;
        tick();
        k = edge_n - 1;
        for (int j = 0; j < 4; j++) begin
            expect_capture(k, "held");
            finish_hs(0, "held");
            tick();
            k = edge_n - 1;
        end
        sample_req = 1'b0;
        expect_capture(k, "held_last");
        finish_hs(0, "held_last");

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            mode   = $urandom_range(0, 2);
            va     = WIDTH'($urandom);
            vb     = WIDTH'($urandom);
            cnt_in = va;
            repeat ($urandom_range(0, 4)) tick();
            request(k);
            expect_capture(k, "rand");
            finish_hs($urandom_range(0, 4), "rand");
        end
        mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
